// File: rtl/count_m10.sv
// Free-running modulo-MODULUS counter with terminal-count flag, wrap pulse,
// wrap counter and seven-segment decode of the current value.
module count_m10 #(
    parameter int unsigned MODULUS    = 10,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned WRAP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [WIDTH-1:0]      counter_value,
    output logic                  terminal_count,
    output logic                  wrap_pulse,
    output logic [WRAP_WIDTH-1:0] wrap_count,
    output logic [6:0]            seg7
);

    localparam logic [WIDTH-1:0] LastValue = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0]      count_q, count_d;
    logic                  pulse_q, pulse_d;
    logic [WRAP_WIDTH-1:0] wraps_q, wraps_d;
    logic                  at_top;
    logic [31:0]           count_ext;

    // Anything at or beyond the last legal value returns to zero.
    assign at_top = (count_q >= LastValue);

    always_comb begin
        count_d = count_q + WIDTH'(1);
        pulse_d = 1'b0;
        wraps_d = wraps_q;
        if (at_top) begin
            count_d = '0;
            pulse_d = 1'b1;
            wraps_d = wraps_q + WRAP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            pulse_q <= 1'b0;
            wraps_q <= '0;
        end else begin
            count_q <= count_d;
            pulse_q <= pulse_d;
            wraps_q <= wraps_d;
        end
    end

    assign counter_value  = count_q;
    assign terminal_count = (count_q == LastValue);
    assign wrap_pulse     = pulse_q;
    assign wrap_count     = wraps_q;
    assign count_ext      = 32'(count_q);

    always_comb begin
        seg7 = 7'h00;
        case (count_ext)
            32'd0:   seg7 = 7'h3F;
            32'd1:   seg7 = 7'h06;
            32'd2:   seg7 = 7'h5B;
            32'd3:   seg7 = 7'h4F;
            32'd4:   seg7 = 7'h66;
            32'd5:   seg7 = 7'h6D;
            32'd6:   seg7 = 7'h7D;
            32'd7:   seg7 = 7'h07;
            32'd8:   seg7 = 7'h7F;
            32'd9:   seg7 = 7'h6F;
            32'd10:  seg7 = 7'h77;
            32'd11:  seg7 = 7'h7C;
            32'd12:  seg7 = 7'h39;
            32'd13:  seg7 = 7'h5E;
            32'd14:  seg7 = 7'h79;
            32'd15:  seg7 = 7'h71;
            default: seg7 = 7'h00;
        endcase
    end

endmodule

// File: tb/tb_count_m10.sv
// Directed testbench for count_m10: decade instance plus a MODULUS=16 instance.
module tb_count_m10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst16 = 1'b0;

    logic [3:0] cv, cv16;
    logic       tc, tc16;
    logic       wp, wp16;
    logic [7:0] wc, wc16;
    logic [6:0] seg, seg16;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    count_m10 dut (
        .clk            (clk),
        .rst            (rst),
        .counter_value  (cv),
        .terminal_count (tc),
        .wrap_pulse     (wp),
        .wrap_count     (wc),
        .seg7           (seg)
    );

    count_m10 #(.MODULUS(16)) dut16 (
        .clk            (clk),
        .rst            (rst16),
        .counter_value  (cv16),
        .terminal_count (tc16),
        .wrap_pulse     (wp16),
        .wrap_count     (wc16),
        .seg7           (seg16)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        int exp_wc;
        int pulses;
        logic saw_roll;
        logic [7:0] prev_wc;

        // 1. reset held with clock running
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cv", 32'(cv), 32'd0);
        check_eq("rst_wp", 32'(wp), 32'd0);
        check_eq("rst_wc", 32'(wc), 32'd0);
        check_eq("rst_tc", 32'(tc), 32'd0);
        check_eq("rst_seg", 32'(seg), 32'h3F);

        // 2. release and count 1..9
        rst = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            check_eq("seq_cv", 32'(cv), 32'(i));
            check_eq("seq_seg", 32'(seg), 32'(seg_tab[i]));
            check_eq("seq_tc", 32'(tc), (i == 9) ? 32'd1 : 32'd0);
            check_eq("seq_wp", 32'(wp), 32'd0);
        end

        // 3. wrap
        step();
        check_eq("wrap_cv", 32'(cv), 32'd0);
        check_eq("wrap_wp", 32'(wp), 32'd1);
        check_eq("wrap_wc", 32'(wc), 32'd1);
        check_eq("wrap_tc", 32'(tc), 32'd0);
        step();
        check_eq("post_cv", 32'(cv), 32'd1);
        check_eq("post_wp", 32'(wp), 32'd0);
        check_eq("post_wc", 32'(wc), 32'd1);

        // 4. async reset mid-cycle at value 5
        repeat (4) step();
        check_eq("mid_cv5", 32'(cv), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_cv", 32'(cv), 32'd0);
        check_eq("arst_wc", 32'(wc), 32'd0);
        check_eq("arst_wp", 32'(wp), 32'd0);
        check_eq("arst_seg", 32'(seg), 32'h3F);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_eq("rel_cv", 32'(cv), 32'd1);
        check_eq("rel_wc", 32'(wc), 32'd0);
        check_eq("rel_wp", 32'(wp), 32'd0);

        // 5. 2560 clocks: 256 wraps, wrap_count rolls over
        exp_cnt = 1;
        exp_wc = 0;
        pulses = 0;
        saw_roll = 1'b0;
        prev_wc = wc;
        for (int i = 0; i < 2560; i++) begin
            step();
            exp_cnt = (exp_cnt + 1) % 10;
            if (exp_cnt == 0) exp_wc = (exp_wc + 1) % 256;
            if (wp) pulses++;
            if (prev_wc == 8'd255 && wc == 8'd0) saw_roll = 1'b1;
            prev_wc = wc;
            check_eq("run_cv", 32'(cv), 32'(exp_cnt));
            check_eq("run_wp", 32'(wp), (exp_cnt == 0) ? 32'd1 : 32'd0);
            check_eq("run_tc", 32'(tc), (exp_cnt == 9) ? 32'd1 : 32'd0);
            check_eq("run_wc", 32'(wc), 32'(exp_wc));
        end
        check_eq("run_pulses", 32'(pulses), 32'd256);
        check_eq("run_roll", 32'(saw_roll), 32'd1);
        check_eq("run_wc_end", 32'(wc), 32'd0);

        // 6. MODULUS = 16 instance
        @(negedge clk);
        check_eq("m16_rst_cv", 32'(cv16), 32'd0);
        check_eq("m16_rst_seg", 32'(seg16), 32'h3F);
        rst16 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check_eq("m16_cv", 32'(cv16), 32'(i % 16));
            check_eq("m16_seg", 32'(seg16), 32'(seg_tab[i % 16]));
            check_eq("m16_tc", 32'(tc16), (i == 15) ? 32'd1 : 32'd0);
            check_eq("m16_wp", 32'(wp16), (i == 16) ? 32'd1 : 32'd0);
        end
        check_eq("m16_wc", 32'(wc16), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
